// File: rtl/dma_fifo_pkg.sv
// ============================================================================
//  Module   : dma_fifo_pkg
//  Purpose  : Shared defaults and types for the multi-channel packet FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_fifo_pkg;
   localparam int C_DWIDTH    = 64;
   localparam int C_AWIDTH    = 6;
   localparam int C_NCH       = 4;
   localparam int C_AF_THRESH = 4;

   // Pointer carries one extra wrap bit above the region address.
   typedef logic [C_AWIDTH:0] ptr_t;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      ptr_t depth_left;
   } chan_status_t;
endpackage

`default_nettype wire

// File: rtl/dma_fifo_chan_ptr.sv
// ============================================================================
//  Module   : dma_fifo_chan_ptr
//  Purpose  : One channel's write/commit/read pointers, bad flag and status.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_fifo_chan_ptr
   import dma_fifo_pkg::*;
#(
   parameter int AWIDTH    = C_AWIDTH,
   parameter int AF_THRESH = C_AF_THRESH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic              i_eop,
   input  logic              i_drop,
   input  logic              i_pull,
   output logic [AWIDTH-1:0] o_wr_addr,
   output logic [AWIDTH-1:0] o_rd_addr,
   output logic              o_write,
   output logic              o_read,
   output logic              o_drop,
   output chan_status_t      o_status
);
   localparam logic [AWIDTH:0] c_depth = {1'b1, {AWIDTH{1'b0}}};
   localparam logic [AWIDTH:0] c_one   = (AWIDTH+1)'(1);
   localparam logic [AWIDTH:0] c_af    = (AWIDTH+1)'(AF_THRESH);

   logic [AWIDTH:0] r_wr_ptr, r_cm_ptr, r_rd_ptr;
   logic            r_bad;
   logic [AWIDTH:0] w_used, w_depth_left;
   logic            w_full, w_empty, w_discard;

   always_comb begin
      w_used       = r_wr_ptr - r_rd_ptr;
      w_depth_left = c_depth - w_used;
      w_full       = (w_used == c_depth);
      w_empty      = (r_cm_ptr == r_rd_ptr);
      // Any eop that closes a failed, flagged or overflowing packet discards it.
      w_discard    = i_push & i_eop & (w_full | i_drop | r_bad);
      o_write      = i_push & ~w_full & ~w_discard;
      o_read       = i_pull & ~w_empty;
      o_drop       = w_discard;
      o_wr_addr    = r_wr_ptr[AWIDTH-1:0];
      o_rd_addr    = r_rd_ptr[AWIDTH-1:0];
      o_status.full        = w_full;
      o_status.empty       = w_empty;
      o_status.almost_full = (w_depth_left <= c_af);
      o_status.depth_left  = w_depth_left;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_cm_ptr <= '0;
         r_rd_ptr <= '0;
         r_bad    <= 1'b0;
      end else begin
         if (w_discard) begin
            r_wr_ptr <= r_cm_ptr;
            r_bad    <= 1'b0;
         end else if (o_write) begin
            r_wr_ptr <= r_wr_ptr + c_one;
            if (i_eop)
               r_cm_ptr <= r_wr_ptr + c_one;
         end else if (i_push) begin
            // Only a non-eop push into a full channel lands here.
            r_bad <= 1'b1;
         end
         if (o_read)
            r_rd_ptr <= r_rd_ptr + c_one;
      end
   end
endmodule

`default_nettype wire

// File: rtl/dma_fifo_mc_pkt.sv
// ============================================================================
//  Module   : dma_fifo_mc_pkt
//  Purpose  : Multi-channel packet FIFO over a shared external buffer memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_fifo_mc_pkt
   import dma_fifo_pkg::*;
#(
   parameter int DWIDTH    = C_DWIDTH,
   parameter int AWIDTH    = C_AWIDTH,
   parameter int NCH       = C_NCH,
   parameter int AF_THRESH = C_AF_THRESH,
   localparam int CW       = $clog2(NCH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [CW-1:0]            push_ch,
   input  logic                     push_eop,
   input  logic                     push_drop,
   input  logic [DWIDTH-1:0]        data_in,
   input  logic                     pull,
   input  logic [CW-1:0]            pull_ch,
   output logic [DWIDTH-1:0]        data_out,
   output logic                     rvalid,
   output logic [CW-1:0]            rch,
   output logic [NCH-1:0]           full,
   output logic [NCH-1:0]           empty,
   output logic [NCH-1:0]           almost_full,
   output logic [NCH*(AWIDTH+1)-1:0] depth_left,
   output logic                     pkt_dropped,
   output logic                     mem_write,
   output logic [CW+AWIDTH-1:0]     mem_waddr,
   output logic [DWIDTH-1:0]        mem_wdata,
   output logic                     mem_read,
   output logic [CW+AWIDTH-1:0]     mem_raddr,
   input  logic [DWIDTH-1:0]        mem_rdata
);
   logic [NCH-1:0]    w_push_sel, w_pull_sel, w_write, w_read, w_drop;
   logic [AWIDTH-1:0] w_wr_addr [NCH];
   logic [AWIDTH-1:0] w_rd_addr [NCH];
   chan_status_t      w_stat    [NCH];

   logic              r_rvalid;
   logic [CW-1:0]     r_rch;
   logic              r_pkt_dropped;

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      assign w_push_sel[c] = push & (push_ch == CW'(c));
      assign w_pull_sel[c] = pull & (pull_ch == CW'(c));

      dma_fifo_chan_ptr #(
         .AWIDTH    (AWIDTH),
         .AF_THRESH (AF_THRESH)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .i_push    (w_push_sel[c]),
         .i_eop     (push_eop),
         .i_drop    (push_drop),
         .i_pull    (w_pull_sel[c]),
         .o_wr_addr (w_wr_addr[c]),
         .o_rd_addr (w_rd_addr[c]),
         .o_write   (w_write[c]),
         .o_read    (w_read[c]),
         .o_drop    (w_drop[c]),
         .o_status  (w_stat[c])
      );

      assign full[c]        = w_stat[c].full;
      assign empty[c]       = w_stat[c].empty;
      assign almost_full[c] = w_stat[c].almost_full;
      assign depth_left[c*(AWIDTH+1) +: AWIDTH+1] = w_stat[c].depth_left;
   end

   // Strobes are forced low during reset, when pointer state may be unknown.
   assign mem_write = rst & (|w_write);
   assign mem_read  = rst & (|w_read);
   assign mem_waddr = {push_ch, w_wr_addr[push_ch]};
   assign mem_raddr = {pull_ch, w_rd_addr[pull_ch]};
   assign mem_wdata = data_in;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rvalid      <= 1'b0;
         r_rch         <= '0;
         r_pkt_dropped <= 1'b0;
      end else begin
         r_rvalid      <= |w_read;
         r_rch         <= pull_ch;
         r_pkt_dropped <= |w_drop;
      end
   end

   // Memory registers its read data, so it lines up with r_rvalid.
   assign data_out    = r_rvalid ? mem_rdata : '0;
   assign rvalid      = r_rvalid;
   assign rch         = r_rch;
   assign pkt_dropped = r_pkt_dropped;

   a_drop_needs_eop : assert property (@(posedge clk) disable iff (!rst)
      (push && push_drop) |-> push_eop);
   a_push_ch_known : assert property (@(posedge clk) disable iff (!rst)
      push |-> !$isunknown(push_ch));
   a_pull_ch_known : assert property (@(posedge clk) disable iff (!rst)
      pull |-> !$isunknown(pull_ch));
endmodule

`default_nettype wire

// File: tb/tb_dma_fifo_mc_pkt.sv
// ============================================================================
//  Module   : tb_dma_fifo_mc_pkt
//  Purpose  : Scoreboard bench for dma_fifo_mc_pkt with a behavioural memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_fifo_mc_pkt;
   localparam int DW = 64, AW = 6, NCH = 4, CW = 2, DEPTH = 64, PW = AW + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic push = 1'b0, push_eop = 1'b0, push_drop = 1'b0, pull = 1'b0;
   logic [CW-1:0] push_ch = '0, pull_ch = '0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out, mem_wdata, mem_rdata;
   logic rvalid, pkt_dropped, mem_write, mem_read;
   logic [CW-1:0] rch;
   logic [NCH-1:0] full, empty, almost_full;
   logic [NCH*PW-1:0] depth_left;
   logic [CW+AW-1:0] mem_waddr, mem_raddr;

   always #5 clk = ~clk;

   dma_fifo_mc_pkt dut (
      .clk(clk), .rst(rst), .push(push), .push_ch(push_ch), .push_eop(push_eop),
      .push_drop(push_drop), .data_in(data_in), .pull(pull), .pull_ch(pull_ch),
      .data_out(data_out), .rvalid(rvalid), .rch(rch), .full(full), .empty(empty),
      .almost_full(almost_full), .depth_left(depth_left), .pkt_dropped(pkt_dropped),
      .mem_write(mem_write), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
   );

   logic [DW-1:0] mem [0:NCH*DEPTH-1];
   always @(posedge clk) begin
      if (mem_write) mem[mem_waddr] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem[mem_raddr];
   end

   int n_vec = 0, n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: unbounded counters per channel, data window indexed mod 256.
   int            m_wr [NCH], m_cm [NCH], m_rd [NCH];
   bit            m_bad [NCH];
   logic [DW-1:0] m_data [NCH][256];

   typedef struct packed { logic [CW-1:0] ch; logic [DW-1:0] d; } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   function automatic int m_used(input int c);
      return m_wr[c] - m_rd[c];
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_wr[c] = 0; m_cm[c] = 0; m_rd[c] = 0; m_bad[c] = 1'b0;
      end
   endtask

   function automatic logic [PW-1:0] dl(input int c);
      logic [NCH*PW-1:0] v;
      v = depth_left;
      return v[c*PW +: PW];
   endfunction

   // One clock of stimulus; strobes are checked before the edge, pkt_dropped after it.
   task automatic drive(input bit p, input int pc, input bit eop, input bit drop,
                        input logic [DW-1:0] d, input bit pl, input int plc);
      bit full_c, empty_c, exp_w, exp_r, exp_dr;
      logic [CW-1:0] pcb, plcb;
      pcb = pc[CW-1:0];
      plcb = plc[CW-1:0];
      push = p; push_ch = pcb; push_eop = eop; push_drop = drop; data_in = d;
      pull = pl; pull_ch = plcb;
      full_c  = p && (m_used(pc) == DEPTH);
      empty_c = (m_cm[plc] == m_rd[plc]);
      exp_dr  = p && eop && (full_c || drop || m_bad[pc]);
      exp_w   = p && !full_c && !exp_dr;
      exp_r   = pl && !empty_c;
      #1;
      check("mem_write", mem_write, exp_w);
      if (exp_w) check("mem_waddr", mem_waddr, {pcb, 6'(m_wr[pc] % DEPTH)});
      check("mem_read", mem_read, exp_r);
      if (exp_r) check("mem_raddr", mem_raddr, {plcb, 6'(m_rd[plc] % DEPTH)});
      if (exp_r) begin
         sb.push_back({plcb, m_data[plc][m_rd[plc] % 256]});
         m_rd[plc]++;
      end
      if (exp_dr) begin
         m_wr[pc] = m_cm[pc]; m_bad[pc] = 1'b0;
      end else if (exp_w) begin
         m_data[pc][m_wr[pc] % 256] = d;
         m_wr[pc]++;
         if (eop) m_cm[pc] = m_wr[pc];
      end else if (p) begin
         m_bad[pc] = 1'b1;
      end
      @(posedge clk); #1;
      push = 1'b0; push_eop = 1'b0; push_drop = 1'b0; pull = 1'b0;
      check("pkt_dropped", pkt_dropped, exp_dr);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, '0, 0, 0);
   endtask

   task automatic chk_status();
      for (int c = 0; c < NCH; c++) begin
         check($sformatf("depth_left[%0d]", c), dl(c), DEPTH - m_used(c));
         check($sformatf("empty[%0d]", c), empty[c], m_cm[c] == m_rd[c]);
         check($sformatf("full[%0d]", c), full[c], m_used(c) == DEPTH);
         check($sformatf("almost_full[%0d]", c), almost_full[c], (DEPTH - m_used(c)) <= 4);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (rvalid) begin
            if (sb.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL rvalid: got unexpected word %0h on ch %0d, required none", data_out, rch);
            end else begin
               mon_e = sb.pop_front();
               check("data_out", data_out, mon_e.d);
               check("rch", rch, mon_e.ch);
            end
         end else begin
            check("data_out_idle", data_out, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pushed;
      model_reset();
      // Reset state, with strobes requested while rst is low.
      repeat (3) @(posedge clk);
      #1;
      push = 1'b1; pull = 1'b1; #1;
      check("mem_write_rst", mem_write, 0);
      check("mem_read_rst", mem_read, 0);
      push = 1'b0; pull = 1'b0;
      check("empty_rst", empty, 4'hF);
      check("full_rst", full, 0);
      check("almost_full_rst", almost_full, 0);
      check("depth_left_rst", depth_left, {4{7'd64}});
      check("rvalid_rst", rvalid, 0);
      check("data_out_rst", data_out, 0);
      check("pkt_dropped_rst", pkt_dropped, 0);
      rst = 1'b1;

      // Three-word packet to ch2, then read it back.
      drive(1, 2, 0, 0, 64'hC200_0000_0000_0001, 0, 0);
      drive(1, 2, 0, 0, 64'hC200_0000_0000_0002, 0, 0);
      check("empty2_uncommitted", empty[2], 1);
      drive(1, 2, 1, 0, 64'hC200_0000_0000_0003, 0, 0);
      check("empty2_committed", empty[2], 0);
      check("depth_left2_61", dl(2), 61);
      chk_status();
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, '0, 1, 2);
      idle();
      check("empty2_drained", empty[2], 1);
      check("depth_left2_64", dl(2), 64);

      // Five-word ch1 packet that fails CRC on its last word.
      for (int i = 0; i < 5; i++)
         drive(1, 1, i == 4, i == 4, 64'hC100_0000_0000_0000 + 64'(i), 0, 0);
      check("depth_left1_after_drop", dl(1), 64);
      check("empty1_after_drop", empty[1], 1);

      // Fill ch0 with sixteen 4-word packets.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 0, (i % 4) == 3, 0, 64'hD000_0000_0000_0000 + 64'(i), 0, 0);
         check("almost_full0", almost_full[0], (63 - i) <= 4);
      end
      check("full0", full[0], 1);
      check("depth_left0_0", dl(0), 0);
      drive(1, 0, 0, 0, 64'hBAD0_0000_0000_0001, 0, 0);
      drive(1, 0, 1, 0, 64'hBAD0_0000_0000_0002, 0, 0);
      check("depth_left0_still_0", dl(0), 0);
      // Push while full alongside an accepted pull on the same channel.
      drive(1, 0, 1, 0, 64'hBAD0_0000_0000_0003, 1, 0);
      check("depth_left0_1", dl(0), 1);
      check("full0_after_pull", full[0], 0);
      for (int i = 0; i < DEPTH - 1; i++) drive(0, 0, 0, 0, '0, 1, 0);
      idle();
      chk_status();

      // ch3 streaming: push and pull every cycle, 40-word packets, pointers wrap.
      pushed = 0;
      for (int cyc = 0; cyc < 400 && (pushed < 200 || m_rd[3] != m_cm[3]); cyc++) begin
         drive(pushed < 200, 3, (pushed % 40) == 39, 0,
               64'hE300_0000_0000_0000 + 64'(pushed), 1, 3);
         if (pushed < 200) pushed++;
      end
      idle();
      check("ch3_words_read", m_rd[3], 200);
      chk_status();

      // Reset mid-packet on ch1 with committed data on ch2.
      for (int i = 0; i < 10; i++)
         drive(1, 2, i == 9, 0, 64'hF200_0000_0000_0000 + 64'(i), 0, 0);
      for (int i = 0; i < 3; i++)
         drive(1, 1, 0, 0, 64'hF100_0000_0000_0000 + 64'(i), 0, 0);
      check("depth_left2_54", dl(2), 54);
      check("sb_drained", sb.size(), 0);
      rst = 1'b0; push = 1'b1; push_ch = 2'd1; #1;
      check("mem_write_midrst", mem_write, 0);
      @(posedge clk); #1;
      rst = 1'b1; push = 1'b0;
      model_reset();
      check("empty_after_rst", empty, 4'hF);
      check("depth_left_after_rst", depth_left, {4{7'd64}});
      check("full_after_rst", full, 0);
      check("rvalid_after_rst", rvalid, 0);

      // Channel still works after reset.
      drive(1, 2, 1, 0, 64'h1234_5678_9ABC_DEF0, 0, 0);
      drive(0, 0, 0, 0, '0, 1, 2);
      idle();
      idle();
      check("sb_final", sb.size(), 0);
      chk_status();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/dma_fifo_mc_pkt.md
# dma_fifo_mc_pkt

Multi-channel packet FIFO for the DMA datapath, the successor to the single-channel external-memory FIFO. NCH logical FIFOs share one external packet-buffer memory, with each channel owning a fixed region of 2^AWIDTH words. Words are written speculatively and only become visible to the reader on end-of-packet commit. A packet flagged bad by the upstream CRC checker is discarded by rewinding the write pointer.

## Interface
- DWIDTH, 64, data word width
- AWIDTH, 6, per-channel address width; DEPTH = 2^AWIDTH words per channel
- NCH, 4, channel count (power of two, ≥2); CW = $clog2(NCH)
- AF_THRESH, 4, almost_full asserts when depth_left ≤ AF_THRESH
- clk  input  1  single clock (the clks.clk domain)
- rst  input  1  synchronous, active-low reset (the clks.rst signal)
- push  input  1  write request
- push_ch  input  CW  target channel of push
- push_eop  input  1  this word ends a packet
- push_drop  input  1  with push_eop: packet failed CRC, discard it
- data_in  input  DWIDTH  write data
- pull  input  1  read request
- pull_ch  input  CW  channel to read
- data_out  output  DWIDTH  read data, valid when rvalid
- rvalid  output  1  data_out valid
- rch  output  CW  channel of data_out
- full, empty, almost_full  output  NCH  per-channel status
- depth_left  output  NCH*(AWIDTH+1)  per-channel free words; channel c occupies bits [c*(AWIDTH+1) +: AWIDTH+1]
- pkt_dropped  output  1  one-cycle pulse when a packet is discarded
- mem_write  output  1  memory write strobe
- mem_waddr  output  CW+AWIDTH  write address {push_ch, wr_ptr}
- mem_wdata  output  DWIDTH  equals data_in
- mem_read  output  1  memory read strobe
- mem_raddr  output  CW+AWIDTH  read address {pull_ch, rd_ptr}
- mem_rdata  input  DWIDTH  memory read data, registered inside the memory (1-cycle latency)

## Operation
- Per-channel state: wr_ptr, cm_ptr (commit), rd_ptr, all AWIDTH+1 bits wide with the MSB as wrap bit. Also a bad flag.
- Status is computed from registered state only:
  - used = wr_ptr − cm_ptr… no: used = wr_ptr − rd_ptr (mod 2^(AWIDTH+1)), so uncommitted words count as occupied.
  - depth_left = DEPTH − used.
  - full = (used == DEPTH).
  - empty = (cm_ptr == rd_ptr).
- Push accepted when push && !full[push_ch]:
  - mem_write=1 and wr_ptr++.
  - On push_eop && !push_drop && !bad: cm_ptr ← wr_ptr+1.
  - On push_eop && (push_drop || bad): the word is not written, wr_ptr ← cm_ptr, bad←0, pkt_dropped=1.
- Push to a full channel: the word is not written and bad←1.
  - If it also carries eop, the packet is dropped immediately: wr_ptr ← cm_ptr, pkt_dropped=1.
- Pull accepted when pull && !empty[pull_ch]: mem_read=1, rd_ptr++.
  - The next cycle gives rvalid=1, rch=pull_ch, data_out=mem_rdata.
  - Pull on an empty channel is ignored, and rvalid=0 next cycle.
- Simultaneous push and pull on the same channel: each is evaluated independently against start-of-cycle status. A push while full is rejected even if a pull is accepted in the same cycle.
- Wrap-around is natural via the wrap bit. The region address is the low AWIDTH bits of the pointer.
- data_out is 0 whenever rvalid=0.

## Timing
- Reset (rst=0 at a clk edge) gives:
  - all pointers 0, bad 0
  - depth_left=DEPTH, empty=all 1, full=0, almost_full=0
  - rvalid=0, data_out=0, pkt_dropped=0
  - mem_write and mem_read combinationally 0 while rst=0
- Reset mid-packet discards all uncommitted and committed data.
- Status updates the cycle after the accepting edge.
- Commit latency: a packet is pullable the cycle after its eop edge.
- Read latency: 1 cycle from pull to rvalid. Back-to-back pulls sustain one word per cycle.
- pkt_dropped pulses in the cycle after the eop edge.
- Assertions:
  - push_drop without push_eop is illegal.
  - X on push_ch or pull_ch when the matching strobe is high is illegal.

## Structure
- Package dma_fifo_pkg holds:
  - default DWIDTH, AWIDTH and NCH
  - the ptr_t typedef, width AWIDTH+1
  - the chan_status_t struct {full, empty, almost_full, depth_left}
- Sub-module dma_fifo_chan_ptr holds one channel's pointers, bad flag and status. It is instantiated NCH times via generate.
- The top level holds channel decode, memory address muxing and the read-return register.

## Test plan
- Reset, then check outputs → empty=4'b1111, full=0, all depth_left=64, rvalid=0.
- Push 3 words to ch2, eop on the 3rd → empty[2]=0 the cycle after eop, depth_left[2]=61. Then pull ×3 → data returns in order with rch=2, then empty[2]=1.
- Push 5 words to ch1, the 5th with eop+push_drop → pkt_dropped pulse, depth_left[1]=64, empty[1]=1, mem_write for only the first 4.
- Fill ch0 with 64 committed words → full[0]=1, almost_full[0] asserted from depth_left=4 onward. Push a 2-word packet → both rejected, pkt dropped at eop, depth_left[0]=0 unchanged.
- Pull and push ch3 every cycle for 200 words across 40-word packets → pointers wrap, data integrity holds, no stalls once committed.
- Assert rst low mid-packet on ch1 with ch2 holding 10 committed words → next cycle all channels empty, depth_left=64.
